// File: rtl/decode_queue.sv
// decode_queue: instruction queue plus decode/dispatch stage.
//
// Fetched instructions enter a DEPTH-entry FIFO through a valid/ready
// handshake. The head entry is decoded every cycle. Its regfile read indices
// are driven combinationally, and the entry is dispatched to RS or LSB plus
// ROB as a registered one-cycle strobe whenever the back end has room.
//
// Ports:
//   clk_in, rst_n_in        clock (rising edge), asynchronous active-low reset
//   rdy_in                  global enable; all state holds while low
//   if_valid/if_ready       fetch handshake; if_pc/if_ins/if_pred_jmp/
//                           if_pred_another form the queued entry
//   get_id_*, get_val_*,    regfile read port for the head instruction
//   get_has_dep_*, get_dep_*
//   rs_full/lsb_full/rob_full  back-end back-pressure
//   rob_clear               flush (empties the queue)
//   rob_free_id             ROB slot assigned to the dispatched instruction
//   is_rs/is_lsb/r_is_ins   dispatch strobes
//   d_*                     dispatched instruction fields
//   count                   queue occupancy
//
// d_type encoding: 0 = Rtype, 1 = Stype, 2 = Btype, 3 = Jtype.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 3
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [31:0]                if_pc,
    input  logic [31:0]                if_ins,
    input  logic [31:0]                if_pred_another,
    input  logic                       if_pred_jmp,
    output logic [4:0]                 get_id_1,
    output logic [4:0]                 get_id_2,
    input  logic [31:0]                get_val_1,
    input  logic [31:0]                get_val_2,
    input  logic                       get_has_dep_1,
    input  logic                       get_has_dep_2,
    input  logic [ROB_W-1:0]           get_dep_1,
    input  logic [ROB_W-1:0]           get_dep_2,
    input  logic                       rs_full,
    input  logic                       lsb_full,
    input  logic                       rob_full,
    input  logic                       rob_clear,
    input  logic [ROB_W-1:0]           rob_free_id,
    output logic                       is_rs,
    output logic                       is_lsb,
    output logic                       r_is_ins,
    output logic [31:0]                d_pc,
    output logic [10:0]                d_op,
    output logic [31:0]                d_imm,
    output logic                       d_iQi,
    output logic                       d_iQj,
    output logic [ROB_W-1:0]           d_Qi,
    output logic [ROB_W-1:0]           d_Qj,
    output logic [31:0]                d_Vi,
    output logic [31:0]                d_Vj,
    output logic [ROB_W-1:0]           d_Qdest,
    output logic [4:0]                 d_rd,
    output logic                       d_pred_jmp,
    output logic [31:0]                d_another,
    output logic [1:0]                 d_type,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_RI    = 7'b0010011;

    localparam logic [1:0] TYPE_R = 2'd0;
    localparam logic [1:0] TYPE_S = 2'd1;
    localparam logic [1:0] TYPE_B = 2'd2;
    localparam logic [1:0] TYPE_J = 2'd3;

    // Queue storage. The head is read combinationally because the regfile
    // indices must be valid in the same cycle the entry is dispatched.
    logic [31:0] pc_mem      [DEPTH];
    logic [31:0] ins_mem     [DEPTH];
    logic [31:0] another_mem [DEPTH];
    logic        jmp_mem     [DEPTH];

    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [PTR_W:0]   count_reg, count_next;

    logic enq, deq;
    logic [31:0] head_ins;
    logic [6:0]  opcode;
    logic [31:0] imm_next;
    logic [1:0]  type_next;
    logic        lsb_op;

    assign if_ready = (count_reg < CNT_FULL) && !rob_clear;
    assign enq      = if_valid && if_ready && rdy_in;
    assign deq      = rdy_in && !rob_clear && (count_reg != '0)
                      && !rs_full && !lsb_full && !rob_full;
    assign count    = count_reg;

    assign head_ins = ins_mem[head_reg];
    assign opcode   = head_ins[6:0];
    assign lsb_op   = (opcode == OP_S) || (opcode == OP_L);

    always_comb begin
        get_id_1 = 5'd0;
        get_id_2 = 5'd0;
        if (count_reg != '0) begin
            if (!(opcode inside {OP_AUIPC, OP_LUI, OP_JAL}))
                get_id_1 = head_ins[19:15];
            if (!(opcode inside {OP_AUIPC, OP_LUI, OP_JAL, OP_JALR, OP_RI, OP_L}))
                get_id_2 = head_ins[24:20];
        end
    end

    always_comb begin
        imm_next = {{20{head_ins[31]}}, head_ins[31:20]};
        case (opcode)
            OP_LUI, OP_AUIPC: imm_next = {head_ins[31:12], 12'b0};
            OP_JAL:           imm_next = {{12{head_ins[31]}}, head_ins[19:12],
                                          head_ins[20], head_ins[30:21], 1'b0};
            OP_S:             imm_next = {{20{head_ins[31]}}, head_ins[31:25],
                                          head_ins[11:7]};
            default:          ;
        endcase
    end

    always_comb begin
        type_next = TYPE_R;
        case (opcode)
            OP_S:            type_next = TYPE_S;
            OP_B:            type_next = TYPE_B;
            OP_JAL, OP_JALR: type_next = TYPE_J;
            default:         ;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (enq) begin
            pc_mem[tail_reg]      <= if_pc;
            ins_mem[tail_reg]     <= if_ins;
            another_mem[tail_reg] <= if_pred_another;
            jmp_mem[tail_reg]     <= if_pred_jmp;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            is_rs      <= 1'b0;
            is_lsb     <= 1'b0;
            r_is_ins   <= 1'b0;
            d_pc       <= '0;
            d_op       <= '0;
            d_imm      <= '0;
            d_iQi      <= 1'b0;
            d_iQj      <= 1'b0;
            d_Qi       <= '0;
            d_Qj       <= '0;
            d_Vi       <= '0;
            d_Vj       <= '0;
            d_Qdest    <= '0;
            d_rd       <= '0;
            d_pred_jmp <= 1'b0;
            d_another  <= '0;
            d_type     <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
                is_rs     <= 1'b0;
                is_lsb    <= 1'b0;
                r_is_ins  <= 1'b0;
            end else begin
                count_reg <= count_next;
                if (enq)
                    tail_reg <= tail_reg + PTR_ONE;
                is_rs    <= deq && !lsb_op;
                is_lsb   <= deq && lsb_op;
                r_is_ins <= deq;
                if (deq) begin
                    head_reg   <= head_reg + PTR_ONE;
                    d_pc       <= pc_mem[head_reg];
                    d_op       <= {head_ins[30], head_ins[14:12], head_ins[6:0]};
                    d_imm      <= imm_next;
                    d_iQi      <= !get_has_dep_1;
                    d_iQj      <= !get_has_dep_2;
                    d_Qi       <= get_dep_1;
                    d_Qj       <= get_dep_2;
                    d_Vi       <= get_val_1;
                    d_Vj       <= get_val_2;
                    d_Qdest    <= rob_free_id;
                    d_rd       <= head_ins[11:7];
                    d_pred_jmp <= jmp_mem[head_reg];
                    d_another  <= another_mem[head_reg];
                    d_type     <= type_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed tests for decode_queue, one task per scenario.
// Inputs are driven 1ns after the rising edge or on the falling edge;
// outputs are sampled on the falling edge.
module tb_decode_queue;
    localparam int DEPTH = 4;
    localparam int ROB_W = 3;
    localparam logic [1:0] T_R = 2'd0, T_S = 2'd1, T_J = 2'd3;
    localparam logic [31:0] INS_ADDI = 32'hFFC08293;   // addi x5,x1,-4
    localparam logic [31:0] INS_SW   = 32'h0021A423;   // sw x2,8(x3)
    localparam logic [31:0] INS_JAL  = 32'h008000EF;   // jal x1,8

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy_in = 1'b1;
    logic if_valid = 1'b0;
    logic if_ready;
    logic [31:0] if_pc = '0, if_ins = '0, if_pred_another = '0;
    logic if_pred_jmp = 1'b0;
    logic [4:0] get_id_1, get_id_2;
    logic [31:0] get_val_1 = 32'd7, get_val_2 = 32'h22;
    logic get_has_dep_1 = 1'b0, get_has_dep_2 = 1'b0;
    logic [ROB_W-1:0] get_dep_1 = '0, get_dep_2 = '0;
    logic rs_full = 1'b0, lsb_full = 1'b0, rob_full = 1'b0, rob_clear = 1'b0;
    logic [ROB_W-1:0] rob_free_id = '0;
    logic is_rs, is_lsb, r_is_ins;
    logic [31:0] d_pc, d_imm, d_Vi, d_Vj, d_another;
    logic [10:0] d_op;
    logic d_iQi, d_iQj, d_pred_jmp;
    logic [ROB_W-1:0] d_Qi, d_Qj, d_Qdest;
    logic [4:0] d_rd;
    logic [1:0] d_type;
    logic [$clog2(DEPTH):0] count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_ins(if_ins),
        .if_pred_another(if_pred_another), .if_pred_jmp(if_pred_jmp),
        .get_id_1(get_id_1), .get_id_2(get_id_2),
        .get_val_1(get_val_1), .get_val_2(get_val_2),
        .get_has_dep_1(get_has_dep_1), .get_has_dep_2(get_has_dep_2),
        .get_dep_1(get_dep_1), .get_dep_2(get_dep_2),
        .rs_full(rs_full), .lsb_full(lsb_full), .rob_full(rob_full),
        .rob_clear(rob_clear), .rob_free_id(rob_free_id),
        .is_rs(is_rs), .is_lsb(is_lsb), .r_is_ins(r_is_ins),
        .d_pc(d_pc), .d_op(d_op), .d_imm(d_imm), .d_iQi(d_iQi), .d_iQj(d_iQj),
        .d_Qi(d_Qi), .d_Qj(d_Qj), .d_Vi(d_Vi), .d_Vj(d_Vj), .d_Qdest(d_Qdest),
        .d_rd(d_rd), .d_pred_jmp(d_pred_jmp), .d_another(d_another),
        .d_type(d_type), .count(count)
    );

    // Offer one instruction for exactly one rising edge.
    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        @(negedge clk);
        if_valid = 1'b1;
        if_pc = pc;
        if_ins = ins;
        if_pred_another = pc + 32'h40;
        @(posedge clk);
        #1 if_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        if (count !== 0 || r_is_ins !== 0 || is_rs !== 0 || is_lsb !== 0 || d_pc !== 0) begin
            fails++;
            $display("FAIL reset_state count=%0d strobes=%b%b%b d_pc=%h expected all 0", count, r_is_ins, is_rs, is_lsb, d_pc);
        end
        tests++;
        if (if_ready !== 1'b1) begin
            fails++; $display("FAIL reset_if_ready got=%b expected=1", if_ready);
        end
        tests++;
        @(negedge clk) rst_n = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_addi;
        push(32'h100, INS_ADDI);
        @(negedge clk);
        if (count !== 1 || get_id_1 !== 5'd1 || get_id_2 !== 5'd0 || r_is_ins !== 0) begin
            fails++;
            $display("FAIL addi_queued count=%0d id1=%0d id2=%0d strobe=%b expected 1/1/0/0", count, get_id_1, get_id_2, r_is_ins);
        end
        tests++;
        @(negedge clk);
        if (is_rs !== 1 || is_lsb !== 0 || d_pc !== 32'h100 || d_imm !== 32'hFFFFFFFC || d_Vi !== 32'd7
            || d_iQi !== 1 || d_rd !== 5'd5 || d_type !== T_R || d_op !== 11'h413 || d_another !== 32'h140) begin
            fails++;
            $display("FAIL addi_dispatch is_rs=%b pc=%h imm=%h Vi=%0d iQi=%b rd=%0d type=%0d op=%h alt=%h expected 1/100/fffffffc/7/1/5/0/413/140",
                     is_rs, d_pc, d_imm, d_Vi, d_iQi, d_rd, d_type, d_op, d_another);
        end
        tests++;
        @(negedge clk);
        if (r_is_ins !== 0 || is_rs !== 0 || d_pc !== 32'h100) begin
            fails++;
            $display("FAIL addi_one_shot strobe=%b is_rs=%b pc=%h expected 0/0/100 (held)", r_is_ins, is_rs, d_pc);
        end
        tests++;
        $display("[TB] addi transaction done");
    endtask

    task automatic test_sw;
        get_has_dep_2 = 1'b1;
        get_dep_2 = 3'd3;
        rob_free_id = 3'd5;
        push(32'h104, INS_SW);
        @(negedge clk);
        if (get_id_1 !== 5'd3 || get_id_2 !== 5'd2) begin
            fails++; $display("FAIL sw_ids id1=%0d id2=%0d expected 3/2", get_id_1, get_id_2);
        end
        tests++;
        @(negedge clk);
        if (is_lsb !== 1 || is_rs !== 0 || d_imm !== 32'd8 || d_iQj !== 0 || d_Qj !== 3'd3
            || d_type !== T_S || d_op !== 11'h123 || d_Qdest !== 3'd5 || d_pc !== 32'h104) begin
            fails++;
            $display("FAIL sw_dispatch is_lsb=%b is_rs=%b imm=%h iQj=%b Qj=%0d type=%0d op=%h Qdest=%0d pc=%h expected 1/0/8/0/3/1/123/5/104",
                     is_lsb, is_rs, d_imm, d_iQj, d_Qj, d_type, d_op, d_Qdest, d_pc);
        end
        tests++;
        get_has_dep_2 = 1'b0;
        get_dep_2 = '0;
        $display("[TB] sw transaction done");
    endtask

    task automatic test_jal;
        push(32'h108, INS_JAL);
        @(negedge clk);
        if (get_id_1 !== 5'd0 || get_id_2 !== 5'd0) begin
            fails++; $display("FAIL jal_ids id1=%0d id2=%0d expected 0/0", get_id_1, get_id_2);
        end
        tests++;
        @(negedge clk);
        if (is_rs !== 1 || d_imm !== 32'd8 || d_type !== T_J || d_rd !== 5'd1) begin
            fails++;
            $display("FAIL jal_dispatch is_rs=%b imm=%h type=%0d rd=%0d expected 1/8/3/1", is_rs, d_imm, d_type, d_rd);
        end
        tests++;
        $display("[TB] jal transaction done");
    endtask

    // Head is nonzero here, so draining DEPTH entries wraps the pointers.
    task automatic test_full;
        rob_full = 1'b1;
        for (int i = 0; i <= DEPTH; i++) push(32'h300 + 32'(4 * i), INS_ADDI);
        @(negedge clk);
        if (count !== DEPTH || if_ready !== 0 || r_is_ins !== 0) begin
            fails++;
            $display("FAIL full_state count=%0d if_ready=%b strobe=%b expected %0d/0/0", count, if_ready, r_is_ins, DEPTH);
        end
        tests++;
        rob_full = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (r_is_ins !== 1 || d_pc !== 32'h300 + 32'(4 * i)) begin
                fails++;
                $display("FAIL full_drain_%0d strobe=%b pc=%h expected 1/%h", i, r_is_ins, d_pc, 32'h300 + 32'(4 * i));
            end
            tests++;
        end
        @(negedge clk);
        if (r_is_ins !== 0 || count !== 0 || get_id_1 !== 0 || get_id_2 !== 0) begin
            fails++;
            $display("FAIL full_empty strobe=%b count=%0d id1=%0d id2=%0d expected all 0", r_is_ins, count, get_id_1, get_id_2);
        end
        tests++;
        $display("[TB] full/wrap transaction done");
    endtask

    task automatic test_clear;
        rob_full = 1'b1;
        push(32'h400, INS_ADDI);
        push(32'h404, INS_ADDI);
        @(negedge clk);
        rob_full = 1'b0;
        rob_clear = 1'b1;
        if_valid = 1'b1;
        if_pc = 32'h4FC;
        if_ins = INS_ADDI;
        #1;
        if (if_ready !== 0 || count !== 2) begin
            fails++; $display("FAIL clear_ready if_ready=%b count=%0d expected 0/2", if_ready, count);
        end
        tests++;
        @(negedge clk);
        rob_clear = 1'b0;
        if_valid = 1'b0;
        if (count !== 0 || r_is_ins !== 0) begin
            fails++; $display("FAIL clear_empty count=%0d strobe=%b expected 0/0", count, r_is_ins);
        end
        tests++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (r_is_ins !== 0 || count !== 0) begin
                fails++; $display("FAIL clear_no_dispatch_%0d strobe=%b count=%0d pc=%h expected 0/0", i, r_is_ins, count, d_pc);
            end
            tests++;
        end
        $display("[TB] rob_clear transaction done");
    endtask

    task automatic test_rdy_pause;
        rob_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) push(32'h500 + 32'(4 * i), INS_SW);
        @(negedge clk);
        rob_full = 1'b0;
        @(negedge clk);
        if (is_lsb !== 1 || d_pc !== 32'h500) begin
            fails++; $display("FAIL pause_first is_lsb=%b pc=%h expected 1/500", is_lsb, d_pc);
        end
        tests++;
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (is_lsb !== 1 || d_pc !== 32'h500 || count !== DEPTH - 1) begin
                fails++;
                $display("FAIL pause_hold_%0d is_lsb=%b pc=%h count=%0d expected 1/500/%0d", i, is_lsb, d_pc, count, DEPTH - 1);
            end
            tests++;
        end
        rdy_in = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            if (is_lsb !== 1 || d_pc !== 32'h500 + 32'(4 * i)) begin
                fails++;
                $display("FAIL pause_resume_%0d is_lsb=%b pc=%h expected 1/%h", i, is_lsb, d_pc, 32'h500 + 32'(4 * i));
            end
            tests++;
        end
        @(negedge clk);
        if (r_is_ins !== 0 || count !== 0) begin
            fails++; $display("FAIL pause_end strobe=%b count=%0d expected 0/0", r_is_ins, count);
        end
        tests++;
        $display("[TB] rdy_in pause transaction done");
    endtask

    task automatic test_reset_midstream;
        rob_full = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h600 + 32'(4 * i), INS_ADDI);
        @(negedge clk);
        if (count !== 3) begin
            fails++; $display("FAIL midreset_pre count=%0d expected 3", count);
        end
        tests++;
        #1 rst_n = 1'b0;
        #1;
        if (count !== 0 || r_is_ins !== 0 || if_ready !== 1 || d_pc !== 0) begin
            fails++;
            $display("FAIL midreset_async count=%0d strobe=%b if_ready=%b pc=%h expected 0/0/1/0", count, r_is_ins, if_ready, d_pc);
        end
        tests++;
        @(negedge clk) rst_n = 1'b1;
        rob_full = 1'b0;
        push(32'h700, INS_ADDI);
        @(negedge clk);
        @(negedge clk);
        if (is_rs !== 1 || d_pc !== 32'h700) begin
            fails++; $display("FAIL midreset_first is_rs=%b pc=%h expected 1/700", is_rs, d_pc);
        end
        tests++;
        $display("[TB] mid-stream reset transaction done");
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sw();
        test_jal();
        test_full();
        test_clear();
        test_rdy_pause();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage with an internal instruction queue. It sits between insfetch and the RS/LSB/ROB dispatch ports. Fetched instructions are accepted through a valid/ready handshake into a DEPTH-entry FIFO, so fetch no longer stalls on every back-end-full cycle. The head entry is decoded, its operands are read from regfile, and it is dispatched as a registered one-cycle strobe to RS or LSB plus ROB. The FIFO is flushed on rob_clear.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- ROB_W, 3: ROB index width (must equal `ROB_R width).
- clk_in  in  1  clock, rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global enable; when low, all state holds.
- if_valid  in  1  fetch offers an instruction.
- if_ready  out  1  queue can accept; equals (count < DEPTH) && !rob_clear.
- if_pc, if_ins, if_pred_another  in  32 each  instruction address, word, and alternate target.
- if_pred_jmp  in  1  predicted taken.
- get_id_1, get_id_2  out  5  regfile read indices (combinational from head).
- get_val_1, get_val_2  in  32  regfile values.
- get_has_dep_1, get_has_dep_2  in  1  register has a pending producer.
- get_dep_1, get_dep_2  in  ROB_W  producer ROB ids.
- rs_full, lsb_full, rob_full  in  1  back-end full flags.
- rob_clear  in  1  misprediction flush.
- rob_free_id  in  ROB_W  ROB slot for the next dispatch.
- is_rs, is_lsb, r_is_ins  out  1  dispatch strobes.
- d_pc  out  32  instruction PC.
- d_op  out  11  {ins[30], ins[14:12], ins[6:0]}; LSB uses bits [9:0].
- d_imm  out  32  decoded immediate.
- d_iQi, d_iQj  out  1  operand ready (= !has_dep).
- d_Qi, d_Qj  out  ROB_W  operand dependency tags.
- d_Vi, d_Vj  out  32  operand values.
- d_Qdest  out  ROB_W  registered rob_free_id.
- d_rd  out  5  destination register.
- d_pred_jmp  out  1  predicted taken.
- d_another  out  32  alternate target.
- d_type  out  2  `Stype/`Btype/`Jtype/`Rtype.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- FIFO uses head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register. Each entry holds pc, ins, pred_jmp, pred_another.
- Enqueue fires on if_valid && if_ready && rdy_in: the entry is written at tail and tail advances.
- Dequeue condition: rdy_in && !rob_clear && count != 0 && !rs_full && !lsb_full && !rob_full.
- Dequeue actions: head advances and all d_* outputs load from the decoded head plus the regfile response.
- Strobes on dequeue: r_is_ins=1; is_lsb=1 for opcodes `os/`ol, otherwise is_rs=1.
- Cycles without a dequeue: all strobes go to 0 and d_* fields hold their values.
- get_id_1 = 0 for `oauipc/`olui/`ojal, else rs1.
- get_id_2 = 0 for `oauipc/`olui/`ojal/`ojalr/`ori/`ol, else rs2.
- When the queue is empty, get_id_1 and get_id_2 are 0.
- d_imm for the RS path: U-imm for `oauipc/`olui, J-imm for `ojal, else I-imm (sign-extended).
- d_imm for the LSB path: I-imm for `ol, S-imm for `os.
- d_type: `os gives `Stype, `ob gives `Btype, `ojal/`ojalr give `Jtype, everything else gives `Rtype.
- Simultaneous enqueue and dequeue: count is unchanged. There is no same-cycle bypass; an instruction enqueued at edge T can dispatch at edge T+1 at the earliest.
- Full queue: if_ready=0, so an enqueue in that cycle is impossible even if a dequeue also occurs.
- rob_clear (sampled while rdy_in=1) empties the queue: head=tail=0, count=0, all strobes 0. Any enqueue offered in that cycle is dropped (if_ready is already 0).
- rdy_in low: pointers, count, strobes and d_* all hold.
- Async reset: pointers, count, all strobes, and every d_* output go to 0.

## Timing
- Enqueue to earliest dispatch strobe: 1 cycle. The strobe is registered and high for exactly one cycle per instruction.
- Back-to-back dispatch sustains 1 instruction per cycle while the back end is not full.
- Full flags are sampled combinationally in the dequeue cycle. A full flag that rises blocks the next strobe immediately.
- if_ready is combinational from count and rob_clear; it does not depend on if_valid.
- Reset assertion takes effect immediately (asynchronously). Release is synchronous to clk_in; the first enqueue is possible on the first edge after release.

## Test plan
- Reset mid-stream with 3 entries queued, then release: count=0, strobes 0, if_ready=1. The first subsequent instruction dispatches with the correct PC.
- Enqueue `addi x5,x1,-4` (0xFFC08293) at PC 0x100 with x1 ready and value 7: one cycle later is_rs=1, d_imm=0xFFFFFFFC, d_Vi=7, d_iQi=1, d_rd=5, d_type=`Rtype, get_id_2 was 0.
- Enqueue `sw x2,8(x3)` with x2 dependent on ROB 3: is_lsb=1, d_imm=8, d_iQj=0, d_Qj=3, d_type=`Stype.
- Hold rob_full=1 while pushing DEPTH+1 instructions: count=DEPTH and if_ready=0 after DEPTH pushes. After release, DEPTH strobes appear in order on consecutive cycles with the PCs preserved across pointer wrap.
- Assert rob_clear with 2 entries queued while if_valid=1: no strobe that cycle, count=0 next cycle, and the offered instruction never dispatches.
- Toggle rdy_in low for 3 cycles mid-burst: no entry is lost or duplicated, and the strobe sequence resumes exactly where it paused.
